// File: rtl/greenhouse_temp_filter_if.sv
// Sensor-sample and filtered-result bundle between the sensor front-end and the
// temperature controller. The master drives the samples; the filter drives the results.
interface greenhouse_temp_filter_if;
  logic signed [7:0] gh_sample;
  logic              gh_valid;
  logic signed [7:0] amb_sample;
  logic              amb_valid;
  logic signed [7:0] greenhouse_temp;
  logic signed [7:0] ambient_temp;
  logic              temp_g_greenhouse_temp;
  logic              data_ready;
  logic              sample_fault;

  modport master (
    output gh_sample, gh_valid, amb_sample, amb_valid,
    input  greenhouse_temp, ambient_temp, temp_g_greenhouse_temp, data_ready, sample_fault
  );

  modport slave (
    input  gh_sample, gh_valid, amb_sample, amb_valid,
    output greenhouse_temp, ambient_temp, temp_g_greenhouse_temp, data_ready, sample_fault
  );
endinterface

// File: rtl/greenhouse_temp_filter.sv
// Two independent boxcar moving averages (greenhouse, ambient) with a hysteretic
// "ambient warmer" flag, window-fill status and a sticky sensor-fault bit.
module greenhouse_temp_filter #(
  parameter int LOG2_WIN = 2,
  parameter int CMP_HYST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  greenhouse_temp_filter_if.slave  bus
);
  localparam int WIN   = 1 << LOG2_WIN;
  localparam int SUM_W = 8 + LOG2_WIN;
  localparam logic [LOG2_WIN:0]   FILL_FULL = (LOG2_WIN + 1)'(WIN);
  localparam logic signed [9:0]   HYST      = 10'(CMP_HYST);
  localparam logic signed [7:0]   ERR_CODE  = 8'sh80;

  logic signed [7:0] sample_s [2];
  logic              valid_s  [2];
  logic signed [7:0] avg_s    [2];
  logic [1:0]        full_d_s;
  logic [1:0]        fault_s;

  assign sample_s[0] = bus.gh_sample;
  assign valid_s[0]  = bus.gh_valid;
  assign sample_s[1] = bus.amb_sample;
  assign valid_s[1]  = bus.amb_valid;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic signed [7:0]       win_q [WIN];
    logic [LOG2_WIN-1:0]     wptr_q, wptr_d;
    logic [LOG2_WIN:0]       fill_q, fill_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic                    accept_s;

    assign accept_s   = valid_s[c] && (sample_s[c] != ERR_CODE);
    assign fault_s[c] = valid_s[c] && (sample_s[c] == ERR_CODE);
    // floor(sum / WIN) is exactly the upper 8 bits of the running sum
    assign avg_s[c]    = sum_q[SUM_W-1 -: 8];
    assign full_d_s[c] = (fill_d == FILL_FULL);

    // Next-state for running sum, write pointer and saturating fill counter
    always_comb begin
      sum_d  = sum_q;
      wptr_d = wptr_q;
      fill_d = fill_q;
      if (accept_s) begin
        sum_d  = sum_q + {{LOG2_WIN{sample_s[c][7]}}, sample_s[c]}
                       - {{LOG2_WIN{win_q[wptr_q][7]}}, win_q[wptr_q]};
        wptr_d = wptr_q + LOG2_WIN'(1);
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + (LOG2_WIN + 1)'(1);
        end else begin
          fill_d = fill_q;
        end
      end else begin
        sum_d  = sum_q;
        wptr_d = wptr_q;
        fill_d = fill_q;
      end
    end

    // Window storage and channel state registers
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < WIN; i++) begin
          win_q[i] <= 8'sd0;
        end
        sum_q  <= '0;
        wptr_q <= '0;
        fill_q <= '0;
      end else begin
        if (accept_s) begin
          win_q[wptr_q] <= sample_s[c];
        end
        sum_q  <= sum_d;
        wptr_q <= wptr_d;
        fill_q <= fill_d;
      end
    end
  end

  logic signed [9:0] gh_w_s, amb_w_s;
  logic              flag_q, flag_d;
  logic              data_ready_q, data_ready_d;
  logic              fault_q, fault_d;

  assign gh_w_s  = {{2{avg_s[0][7]}}, avg_s[0]};
  assign amb_w_s = {{2{avg_s[1][7]}}, avg_s[1]};

  // Hysteretic comparison of the registered averages, plus sticky status bits
  always_comb begin
    flag_d       = flag_q;
    data_ready_d = data_ready_q | (&full_d_s);
    fault_d      = fault_q | (|fault_s);
    if (!data_ready_q) begin
      flag_d = 1'b0;
    end else if (amb_w_s > gh_w_s + HYST) begin
      flag_d = 1'b1;
    end else if (amb_w_s < gh_w_s - HYST) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // Status and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q       <= 1'b0;
      data_ready_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      flag_q       <= flag_d;
      data_ready_q <= data_ready_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.greenhouse_temp        = avg_s[0];
  assign bus.ambient_temp           = avg_s[1];
  assign bus.temp_g_greenhouse_temp = flag_q;
  assign bus.data_ready             = data_ready_q;
  assign bus.sample_fault           = fault_q;
endmodule
